// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage (sign/zero/upper/branch) with valid/ready handshake.
// Define IMM_EXT_SKID_EN for the 2-entry skid build with a registered in_ready.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out
);

  localparam int unsigned PadW = OUT_W - IN_W;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
    logic [OUT_W-1:0] sext;
    sext = {{PadW{d[IN_W-1]}}, d};
    unique case (m)
      2'b00:   extend = sext;
      2'b01:   extend = {{PadW{1'b0}}, d};
      2'b10:   extend = {d, {PadW{1'b0}}};
      default: extend = {sext[OUT_W-3:0], 2'b00};
    endcase
  endfunction

  logic [OUT_W-1:0] ext_res;
  logic             accept;
  logic             drain;
  logic             out_valid_q;
  logic [OUT_W-1:0] data_q;

  assign ext_res   = extend(data_in, mode);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;

`ifdef IMM_EXT_SKID_EN

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic [OUT_W-1:0] skid_q;

  assign in_ready = in_ready_q;

  // in_ready is a pure register: low exactly while both entries are full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      data_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            data_q      <= ext_res;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && !drain) begin
            skid_q     <= ext_res;
            in_ready_q <= 1'b0;
            state_q    <= StTwo;
          end else if (accept && drain) begin
            data_q <= ext_res;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StTwo: begin
          if (drain) begin
            data_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`else

  assign in_ready = ~out_valid_q | out_ready;

  // data_q only loads on accept, so it holds its last value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      data_q      <= ext_res;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe: vector table plus backpressure/reset sequences.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;

  int checks;
  int errors;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] expect_out;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then step to just after the next rising edge.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [15:0] d, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    mode      = m;
    data_in   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    mode      = 2'b00;
    data_in   = 16'h0;
    out_ready = 1'b1;

    vecs[0] = '{mode: 2'b00, data: 16'h8000, expect_out: 32'hFFFF8000};
    vecs[1] = '{mode: 2'b00, data: 16'h7FFF, expect_out: 32'h00007FFF};
    vecs[2] = '{mode: 2'b01, data: 16'h8000, expect_out: 32'h00008000};
    vecs[3] = '{mode: 2'b10, data: 16'h1234, expect_out: 32'h12340000};
    vecs[4] = '{mode: 2'b11, data: 16'hFFFF, expect_out: 32'hFFFFFFFC};
    vecs[5] = '{mode: 2'b11, data: 16'h0004, expect_out: 32'h00000010};
    vecs[6] = '{mode: 2'b01, data: 16'hFFFF, expect_out: 32'h0000FFFF};
    vecs[7] = '{mode: 2'b10, data: 16'hFFFF, expect_out: 32'hFFFF0000};
    vecs[8] = '{mode: 2'b11, data: 16'h8000, expect_out: 32'hFFFE0000};
    vecs[9] = '{mode: 2'b00, data: 16'h0000, expect_out: 32'h00000000};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset data_out", data_out, 32'h0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // T1-T3 plus extra patterns, back-to-back with out_ready high
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].mode, vecs[i].data, 1'b1);
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].expect_out);
    end
    cycle(1'b0, 2'b00, 16'h0, 1'b1);
    check("drain out_valid", {31'b0, out_valid}, 32'd0);
    check("held data_out", data_out, 32'h00000000);
    // mode/data_in are ignored while in_valid is low
    cycle(1'b0, 2'b10, 16'hABCD, 1'b1);
    check("idle out_valid", {31'b0, out_valid}, 32'd0);
    check("idle data_out", data_out, 32'h00000000);

    // T4 backpressure: A then B with out_ready low
    cycle(1'b1, 2'b00, 16'h0001, 1'b0);
    check("T4 A out_valid", {31'b0, out_valid}, 32'd1);
    check("T4 A data_out", data_out, 32'h1);
`ifdef IMM_EXT_SKID_EN
    check("T4 in_ready one", {31'b0, in_ready}, 32'd1);
    cycle(1'b1, 2'b00, 16'h0002, 1'b0);
    check("T4 in_ready full", {31'b0, in_ready}, 32'd0);
    cycle(1'b0, 2'b00, 16'h0, 1'b0);
    check("T4 stable data_out", data_out, 32'h1);
    cycle(1'b0, 2'b00, 16'h0, 1'b1);
`else
    cycle(1'b1, 2'b00, 16'h0002, 1'b0);
    check("T4 in_ready stall", {31'b0, in_ready}, 32'd0);
    cycle(1'b1, 2'b00, 16'h0002, 1'b0);
    check("T4 stable data_out", data_out, 32'h1);
    cycle(1'b1, 2'b00, 16'h0002, 1'b1);
`endif
    check("T4 B out_valid", {31'b0, out_valid}, 32'd1);
    check("T4 B data_out", data_out, 32'h2);
    cycle(1'b0, 2'b00, 16'h0, 1'b1);
    check("T4 empty out_valid", {31'b0, out_valid}, 32'd0);
    check("T4 held data_out", data_out, 32'h2);

    // T5 eight back-to-back beats, no bubbles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("T5 beat%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      mode      = 2'b01;
      data_in   = 16'(16'hF000 + 16'(i * 3));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("T5 beat%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("T5 beat%0d data_out", i), data_out, 32'h0000F000 + 32'(i * 3));
    end
    cycle(1'b0, 2'b00, 16'h0, 1'b1);

    // T6 reset mid-operation with results held
    cycle(1'b1, 2'b00, 16'h0011, 1'b0);
    cycle(1'b1, 2'b00, 16'h0022, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("T6 out_valid", {31'b0, out_valid}, 32'd0);
    check("T6 data_out", data_out, 32'h0);
    check("T6 in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'b10, 16'h00FF, 1'b1);
    check("T6 post out_valid", {31'b0, out_valid}, 32'd1);
    check("T6 post data_out", data_out, 32'h00FF0000);
    cycle(1'b0, 2'b00, 16'h0, 1'b1);
    check("T6 no duplicate", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
